// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and state encodings for the parametrised multi-cycle ALU
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// rtl/alu_shift_add_mul.sv - iterative LSB-first shift-add multiplier datapath
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [CW-1:0]      cnt_q;

  // product is the accumulator value after the current step, so the final
  // step's contribution is already included when last is high
  assign product = acc_q + (b_sh_q[0] ? a_sh_q : '0);
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      acc_q  <= '0;
      a_sh_q <= {{WIDTH{1'b0}}, a};
      b_sh_q <= b;
      cnt_q  <= '0;
    end else if (step) begin
      acc_q  <= product;
      a_sh_q <= a_sh_q << 1;
      b_sh_q <= b_sh_q >> 1;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_alu_param.sv
// rtl/multicycle_alu_param.sv - WIDTH-bit multi-cycle ALU with start/done/busy handshake
module multicycle_alu_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         Op,
  output logic [2*WIDTH-1:0] Y,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] y_q;
  logic               zero_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] res_d;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_last;
  logic               mul_load;
  logic               mul_step;

  assign mul_load = (state_q == ST_IDLE) && start && (Op == OP_MUL);
  assign mul_step = (state_q == ST_MUL);

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .a       (A),
    .b       (B),
    .product (mul_product),
    .last    (mul_last)
  );

  always_comb begin
    res_d = '0;
    case (op_q)
      OP_ADD:  res_d[WIDTH:0]   = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  res_d[WIDTH:0]   = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  res_d[WIDTH-1:0] = a_q & b_q;
      OP_OR:   res_d[WIDTH-1:0] = a_q | b_q;
      OP_XOR:  res_d[WIDTH-1:0] = a_q ^ b_q;
      OP_SHL:  res_d[WIDTH-1:0] = a_q << b_q[SHW-1:0];
      OP_SHR:  res_d[WIDTH-1:0] = a_q >> b_q[SHW-1:0];
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      y_q     <= '0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= Op;
            busy_q  <= 1'b1;
            state_q <= (Op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          y_q     <= res_d;
          zero_q  <= (res_d == '0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_MUL: begin
          if (mul_last) begin
            y_q     <= mul_product;
            zero_q  <= (mul_product == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Y    = y_q;
  assign zero = zero_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multicycle_alu_param.sv
// tb/tb_multicycle_alu_param.sv - self-checking bench for multicycle_alu_param (WIDTH=8)
module tb_multicycle_alu_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [2:0]  Op = '0;
  logic [15:0] Y;
  logic        zero;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

  multicycle_alu_param #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Op    (Op),
    .Y     (Y),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = (a + 512 - b) % 512;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a * (1 << (b % 8))) % 256;
      6: r = a / (1 << (b % 8));
      default: r = a * b;
    endcase
    return r[15:0];
  endfunction

  function automatic int model_lat(input int op);
    return (op == 7) ? 8 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] y, output logic z, output int lat, output bit busy_ok);
    A = a; B = b; Op = op; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy) busy_ok = 1'b0;
    y = Y;
    z = zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total_cnt += 4;
    if (Y !== 16'h0000) $display("FAIL reset_y got %h exp 0000", Y); else pass_cnt++;
    if (zero !== 1'b1) $display("FAIL reset_zero got %b exp 1", zero); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd4, 3'd7, 3'd7};
    logic [7:0]  as  [5] = '{8'hFF, 8'h03, 8'hA5, 8'hFF, 8'h0C};
    logic [7:0]  bs  [5] = '{8'h01, 8'h05, 8'hA5, 8'hFF, 8'h0A};
    logic [15:0] exp [5] = '{16'h0100, 16'h01FE, 16'h0000, 16'hFE01, 16'h0078};
    int          elat [5] = '{1, 1, 1, 8, 8};
    logic [15:0] y;
    logic        z;
    int          lat;
    bit          bok;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], y, z, lat, bok);
      total_cnt += 4;
      if (y !== exp[i]) $display("FAIL dir%0d_y got %h exp %h", i, y, exp[i]); else pass_cnt++;
      if (z !== (exp[i] == 16'h0)) $display("FAIL dir%0d_zero got %b exp %b", i, z, exp[i] == 16'h0); else pass_cnt++;
      if (lat != elat[i]) $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, elat[i]); else pass_cnt++;
      if (!bok) $display("FAIL dir%0d_busy got bad busy window exp busy until done", i); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [15:0] y;
    logic        z;
    int          lat;
    bit          bok;
    int          op, a, b;
    logic [15:0] e;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (i % 8 == 0) b = a;
      e = model(op, a, b);
      do_op(op[2:0], a[7:0], b[7:0], y, z, lat, bok);
      total_cnt += 4;
      if (y !== e) $display("FAIL rnd%0d_y op %0d a %h b %h got %h exp %h", i, op, a, b, y, e); else pass_cnt++;
      if (z !== (e == 16'h0)) $display("FAIL rnd%0d_zero got %b exp %b", i, z, e == 16'h0); else pass_cnt++;
      if (lat != model_lat(op)) $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, model_lat(op)); else pass_cnt++;
      if (!bok) $display("FAIL rnd%0d_busy got bad busy window exp busy until done", i); else pass_cnt++;
    end
  endtask

  task automatic test_start_while_busy();
    int          dones = 0;
    logic [15:0] y_at_done = '0;
    A = 8'hFF; B = 8'hFF; Op = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 8'h01; B = 8'h01; Op = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        dones++;
        y_at_done = Y;
      end
      tick();
    end
    total_cnt += 3;
    if (dones != 1) $display("FAIL busy_start_dones got %0d exp 1", dones); else pass_cnt++;
    if (y_at_done !== 16'hFE01) $display("FAIL busy_start_y got %h exp fe01", y_at_done); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul();
    int          dones = 0;
    logic [15:0] y;
    logic        z;
    int          lat;
    bit          bok;
    A = 8'h37; B = 8'h59; Op = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    total_cnt += 4;
    if (Y !== 16'h0000) $display("FAIL midrst_y got %h exp 0000", Y); else pass_cnt++;
    if (zero !== 1'b1) $display("FAIL midrst_zero got %b exp 1", zero); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else pass_cnt++;
    if (done !== 1'b0) $display("FAIL midrst_done got %b exp 0", done); else pass_cnt++;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      tick();
    end
    total_cnt += 2;
    if (dones != 0) $display("FAIL midrst_no_done got %0d exp 0", dones); else pass_cnt++;
    do_op(3'd0, 8'h01, 8'h02, y, z, lat, bok);
    if (y !== 16'h0003) $display("FAIL midrst_add got %h exp 0003", y); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    A = 8'h81; B = 8'h01; Op = 3'd5; start = 1'b1;
    tick();
    A = 8'h81; B = 8'h03; Op = 3'd6;
    tick();
    total_cnt += 2;
    if (done !== 1'b1) $display("FAIL b2b_done1 got %b exp 1", done); else pass_cnt++;
    if (Y !== 16'h0002) $display("FAIL b2b_shl got %h exp 0002", Y); else pass_cnt++;
    tick();
    start = 1'b0;
    total_cnt += 2;
    if (done !== 1'b0) $display("FAIL b2b_gap got %b exp 0", done); else pass_cnt++;
    if (busy !== 1'b1) $display("FAIL b2b_busy2 got %b exp 1", busy); else pass_cnt++;
    tick();
    total_cnt += 2;
    if (done !== 1'b1) $display("FAIL b2b_done2 got %b exp 1", done); else pass_cnt++;
    if (Y !== 16'h0010) $display("FAIL b2b_shr got %h exp 0010", Y); else pass_cnt++;
    tick();
  endtask

  always @(negedge clk) begin
    if (!reset && done && busy) begin
      $display("FAIL done_busy_overlap got 1 exp 0");
      total_cnt++;
    end
  end

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
